parity_frame_receiver: RTL and testbench
========================================

# parity_frame_receiver

Serial receiver that sits downstream of a parity generator on a one-bit link. It assembles a framed serial stream (start bit, data bits, parity bit, stop bit) into a parallel word and checks the received parity against the configured even/odd scheme. It also flags framing errors and keeps a saturating per-frame error count. Consumers take `data_out` on the `data_valid` pulse and use `parity_error` to qualify it.

## Interface
- `DATA_W`, default 8: data bits per frame, minimum 1.
- `ODD_PARITY`, default 0: 0 selects even parity (total ones in data+parity even); 1 selects odd parity.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bit_valid`  in  1  sample strobe; `bit_in` is consumed only on cycles where this is 1.
- `bit_in`  in  1  serial line; idles at 1.
- `err_clr`  in  1  synchronous clear of `err_count`.
- `data_out`  out  DATA_W  last successfully framed word, LSB received first.
- `data_valid`  out  1  one-cycle pulse: new word on `data_out`.
- `parity_error`  out  1  one-cycle pulse, coincident with `data_valid`, when parity mismatched.
- `frame_error`  out  1  one-cycle pulse when the stop bit sampled 0.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `err_count`  out  8  frames with parity or framing error; saturates at 255.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP. Transitions happen only on cycles with `bit_valid`=1; with `bit_valid`=0 all state, counters and the shift register hold.
- IDLE:
  - `bit_in`=1 means line idle: stay in IDLE.
  - `bit_in`=0 is the start bit: go to DATA, clear the bit counter and the parity accumulator.
- DATA: shift `bit_in` into position [count] (LSB first) and XOR it into the accumulator. After the DATA_W-th bit, go to PARITY.
- PARITY: latch the parity bit. The mismatch rule is mismatch = accumulator ^ parity_bit ^ ODD_PARITY. Go to STOP.
- STOP, `bit_in`=1 (valid frame):
  - `data_out` <= assembled word.
  - `data_valid`=1.
  - `parity_error` = mismatch.
  - If mismatch, increment `err_count`.
- STOP, `bit_in`=0 (framing error):
  - `frame_error`=1; `data_valid` and `parity_error` stay 0.
  - `data_out` is unchanged.
  - Increment `err_count` once; parity is ignored.
- STOP always returns to IDLE. A stop bit of 0 is not treated as a new start bit.
- `err_count` increments at most once per frame and holds at 255 when saturated.
- `err_clr`=1 forces `err_count` to 0. It takes priority over a same-cycle increment, so the result is 0.
- `busy` = (state != IDLE). This is combinational from the state register.

## Timing
- All outputs except `busy` are registered.
- `data_out`, `data_valid`, `parity_error`, `frame_error` and the `err_count` increment all update on the clock edge that samples the stop bit. The pulses are high for exactly the following cycle.
- Minimum frame length is DATA_W+3 strobed bits. Back-to-back frames need no idle bits: a start bit may arrive on the strobe immediately after the stop bit.
- Reset (`rst_n`=0), whether idle or mid-frame:
  - Takes effect immediately; state goes to IDLE and any partial frame is discarded.
  - `data_out`=0, `data_valid`=0, `parity_error`=0, `frame_error`=0, `err_count`=0, `busy`=0.
  - The shift register, bit counter and accumulator are cleared to 0.
- Strobe gaps of any length are allowed anywhere within a frame. `busy` stays high throughout.

## Test plan
All scenarios use DATA_W=8 unless stated.
- **Clean even frame:** ODD_PARITY=0; send start 0, data 0xA5 LSB-first, parity 0, stop 1 -> `data_out`=0xA5; `data_valid`=1 for one cycle; `parity_error`=0; `err_count`=0.
- **Bad parity with strobe gaps:** send 0xA5 with parity 1, inserting 3 idle `bit_valid`=0 cycles between every bit -> `data_out`=0xA5, `data_valid`=1, `parity_error`=1, `err_count`=1.
- **Framing error:** send 0x3C with correct parity but stop bit 0 -> `frame_error`=1, `data_valid`=0, `data_out` keeps its previous value (0xA5), `err_count` increments by 1. The next frame 0x01 (parity 1, stop 1) is received cleanly.
- **Reset mid-frame:** assert `rst_n`=0 after 4 data bits of 0xFF -> all outputs go to 0 and `busy`=0 immediately. After release, frame 0x5A (parity 0) gives `data_out`=0x5A with no errors.
- **Saturation and clear:** send 300 bad-parity frames -> `err_count`=255. Assert `err_clr` on the same edge as another bad frame's stop bit -> `err_count`=0.
- **Odd parity:** ODD_PARITY=1; send 0x07 with parity 0 -> `parity_error`=0. Send 0x07 with parity 1 -> `parity_error`=1.

Source files
------------

// File: rtl/parity_frame_receiver.sv
// parity_frame_receiver
//   Assembles a strobed serial stream (start 0, DATA_W data bits LSB first,
//   parity bit, stop 1) into a parallel word. It checks parity against the
//   configured even/odd scheme, flags bad stop bits, and keeps a saturating
//   count of bad frames.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bit_valid    sample strobe; bit_in is consumed only when high
//   bit_in       serial line, idles high
//   err_clr      synchronous clear of err_count (wins over an increment)
//   data_out     last correctly framed word
//   data_valid   one-cycle pulse, new word on data_out
//   parity_error one-cycle pulse with data_valid on parity mismatch
//   frame_error  one-cycle pulse when the stop bit sampled 0
//   busy         FSM not idle (combinational)
//   err_count    saturating count of frames with parity or framing error
module parity_frame_receiver #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_error,
  output logic              frame_error,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              acc_q;
  logic              par_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q, parity_error_q, frame_error_q;
  logic [7:0]        err_count_q, err_count_d;
  logic              mismatch;
  logic              err_inc;

  assign mismatch = acc_q ^ par_q ^ ODD_PARITY;
  // A bad stop bit counts once and masks any parity mismatch.
  assign err_inc  = bit_valid && (state_q == STOP) && (!bit_in || mismatch);

  always_comb begin
    err_count_d = err_count_q;
    if (err_clr)
      err_count_d = 8'd0;
    else if (err_inc && err_count_q != 8'hFF)
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      acc_q          <= 1'b0;
      par_q          <= 1'b0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      err_count_q    <= 8'd0;
    end else begin
      // Pulses last exactly one cycle, independent of the strobe.
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      err_count_q    <= err_count_d;
      if (bit_valid) begin
        case (state_q)
          IDLE: begin
            if (!bit_in) begin
              state_q <= DATA;
              cnt_q   <= '0;
              acc_q   <= 1'b0;
            end
          end
          DATA: begin
            shift_q[cnt_q] <= bit_in;
            acc_q          <= acc_q ^ bit_in;
            cnt_q          <= cnt_q + 1'b1;
            if (cnt_q == CW'(DATA_W - 1)) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= bit_in;
            state_q <= STOP;
          end
          STOP: begin
            // A 0 stop bit is not a start bit; always return to IDLE.
            if (bit_in) begin
              data_out_q     <= shift_q;
              data_valid_q   <= 1'b1;
              parity_error_q <= mismatch;
            end else begin
              frame_error_q  <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign err_count    = err_count_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Bench: an even-parity and an odd-parity receiver share one serial stream.
// A frame-level model predicts data_out / pulses / err_count for each.
module tb_parity_frame_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b1;
  logic       err_clr = 1'b0;

  logic [7:0] dout [2];
  logic       dv   [2];
  logic       pe   [2];
  logic       fe   [2];
  logic       bsy  [2];
  logic [7:0] ecnt [2];

  int tests = 0;
  int fails = 0;

  // model state per receiver: 0 = even, 1 = odd
  logic [7:0] m_data [2];
  int         m_err  [2];

  always #5 clk = ~clk;

  parity_frame_receiver #(.DATA_W(8), .ODD_PARITY(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .err_clr(err_clr), .data_out(dout[0]), .data_valid(dv[0]),
    .parity_error(pe[0]), .frame_error(fe[0]), .busy(bsy[0]),
    .err_count(ecnt[0]));

  parity_frame_receiver #(.DATA_W(8), .ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .err_clr(err_clr), .data_out(dout[1]), .data_valid(dv[1]),
    .parity_error(pe[1]), .frame_error(fe[1]), .busy(bsy[1]),
    .err_count(ecnt[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_dout"}, 32'(dout[k]), 32'(m_data[k]));
      chk({tag, "_dv"},   32'(dv[k]),   0);
      chk({tag, "_pe"},   32'(pe[k]),   0);
      chk({tag, "_fe"},   32'(fe[k]),   0);
      chk({tag, "_busy"}, 32'(bsy[k]),  0);
      chk({tag, "_ecnt"}, 32'(ecnt[k]), 32'(m_err[k]));
    end
  endtask

  // One strobed bit preceded by 'gap' unstrobed cycles carrying junk.
  task automatic drive_bit(input logic b, input int gap, input logic clr);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
    err_clr   = clr;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int gap, input logic clr, input string tag);
    logic pulse_ok;
    drive_bit(1'b0, gap, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_busy_start"}, 32'(bsy[k]), 1);
      chk({tag, "_dv_drop"},    32'(dv[k]),  0);
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i], gap, 1'b0);
    drive_bit(par, gap, 1'b0);
    for (int k = 0; k < 2; k++)
      chk({tag, "_busy_par"}, 32'(bsy[k]), 1);
    drive_bit(stop, gap, clr);
    // frame-level model
    for (int k = 0; k < 2; k++) begin
      logic mis;
      logic err;
      mis = (((32'($countones(d)) + 32'(par)) % 2) != 32'(k));
      err = !stop || mis;
      if (stop) m_data[k] = d;
      if (clr) m_err[k] = 0;
      else if (err && m_err[k] < 255) m_err[k]++;
      chk({tag, "_dout"}, 32'(dout[k]), 32'(m_data[k]));
      chk({tag, "_dv"},   32'(dv[k]),   32'(stop));
      chk({tag, "_pe"},   32'(pe[k]),   32'(stop && mis));
      chk({tag, "_fe"},   32'(fe[k]),   32'(!stop));
      chk({tag, "_ecnt"}, 32'(ecnt[k]), 32'(m_err[k]));
      chk({tag, "_busy_end"}, 32'(bsy[k]), 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_data[k] = 8'h00;
      m_err[k]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // idle line strobed high must not start a frame
    drive_bit(1'b1, 0, 1'b0);
    chk_idle_outs("idle_ones");

    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0, "clean_even");
    send_frame(8'hA5, 1'b1, 1'b1, 3, 1'b0, "bad_par_gaps");
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, "frame_err");
    send_frame(8'h01, 1'b1, 1'b1, 0, 1'b0, "after_ferr");

    // reset in the middle of a frame of 0xFF
    drive_bit(1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_data[k] = 8'h00;
      m_err[k]  = 0;
    end
    #1;
    chk_idle_outs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0, "post_reset");

    // saturation, then clear on the same edge as a bad stop bit
    for (int n = 0; n < 300; n++)
      send_frame(8'(n), 1'($countones(8'(n)) + 1), 1'b1, 0, 1'b0, "sat");
    chk("sat_even_255", 32'(ecnt[0]), 255);
    send_frame(8'h11, 1'b1, 1'b1, 0, 1'b1, "clr_same_edge");

    // odd-parity receiver directed cases
    send_frame(8'h07, 1'b0, 1'b1, 0, 1'b0, "odd_07_p0");
    send_frame(8'h07, 1'b1, 1'b1, 1, 1'b0, "odd_07_p1");

    // randomized frames, random gaps, occasional bad stop bit
    for (int n = 0; n < 40; n++)
      send_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 6) != 0),
                 int'($urandom_range(0, 2)), 1'b0, "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
